// File: rtl/cci_mpf_fiu_mem_responder.sv
// cci_mpf_fiu_mem_responder
// Stand-in for the FIU in simulation and loopback builds. AFU read (c0) and
// write/fence (c1) requests are queued in per-channel FIFOs and serviced
// against a local line-addressed memory, producing c0/c1 responses.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   c0tx_valid/addr/mdata           read requests from the AFU
//   c0tx_almfull                    read FIFO almost full (registered)
//   c1tx_valid/fence/addr/data/mdata write or fence requests from the AFU
//   c1tx_almfull                    write FIFO almost full (registered)
//   c0rx_rd_valid/mdata/data        read responses, RD_LATENCY after pop
//   c1rx_wr_valid/fence/mdata       write/fence acks, one cycle after pop
//   overflow_err                    sticky: a request hit a full FIFO
module cci_mpf_fiu_mem_responder #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned MDATA_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned ALMFULL_SLACK = 3,
    parameter int unsigned RD_LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c0tx_valid,
    input  logic [ADDR_WIDTH-1:0]  c0tx_addr,
    input  logic [MDATA_WIDTH-1:0] c0tx_mdata,
    output logic                   c0tx_almfull,
    input  logic                   c1tx_valid,
    input  logic                   c1tx_fence,
    input  logic [ADDR_WIDTH-1:0]  c1tx_addr,
    input  logic [DATA_WIDTH-1:0]  c1tx_data,
    input  logic [MDATA_WIDTH-1:0] c1tx_mdata,
    output logic                   c1tx_almfull,
    output logic                   c0rx_rd_valid,
    output logic [MDATA_WIDTH-1:0] c0rx_mdata,
    output logic [DATA_WIDTH-1:0]  c0rx_data,
    output logic                   c1rx_wr_valid,
    output logic                   c1rx_fence,
    output logic [MDATA_WIDTH-1:0] c1rx_mdata,
    output logic                   overflow_err
);

    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned MEM_LINES  = 2 ** ADDR_WIDTH;
    localparam int unsigned ALM_THRESH = FIFO_DEPTH - ALMFULL_SLACK;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALM_CNT  = CNT_W'(ALM_THRESH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [MDATA_WIDTH-1:0] mdata;
    } rd_req_t;

    typedef struct packed {
        logic                   fence;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  data;
        logic [MDATA_WIDTH-1:0] mdata;
    } wr_req_t;

    // ------------------------------------------------------------------
    // Read request FIFO
    // ------------------------------------------------------------------
    rd_req_t          rd_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_wptr;
    logic [PTR_W-1:0] rd_rptr;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] rd_count_nxt;
    logic             rd_full;
    logic             rd_push;
    logic             rd_pop;
    rd_req_t          rd_head;

    // Push is judged against pre-pop occupancy, so a full FIFO drops it.
    assign rd_full = (rd_count == FULL_CNT);
    assign rd_push = c0tx_valid && !rd_full;
    assign rd_pop  = (rd_count != '0);
    assign rd_head = rd_fifo[rd_rptr];

    always_comb begin
        rd_count_nxt = rd_count;
        if (rd_push && !rd_pop) begin
            rd_count_nxt = rd_count + CNT_W'(1);
        end else if (!rd_push && rd_pop) begin
            rd_count_nxt = rd_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wptr      <= '0;
            rd_rptr      <= '0;
            rd_count     <= '0;
            c0tx_almfull <= 1'b0;
        end else begin
            if (rd_push) rd_wptr <= rd_wptr + PTR_W'(1);
            if (rd_pop)  rd_rptr <= rd_rptr + PTR_W'(1);
            rd_count     <= rd_count_nxt;
            c0tx_almfull <= (rd_count_nxt >= ALM_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) rd_fifo[rd_wptr] <= '{addr: c0tx_addr, mdata: c0tx_mdata};
    end

    // ------------------------------------------------------------------
    // Write/fence request FIFO
    // ------------------------------------------------------------------
    wr_req_t          wr_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_wptr;
    logic [PTR_W-1:0] wr_rptr;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] wr_count_nxt;
    logic             wr_full;
    logic             wr_push;
    logic             wr_pop;
    wr_req_t          wr_head;

    assign wr_full = (wr_count == FULL_CNT);
    assign wr_push = c1tx_valid && !wr_full;
    assign wr_pop  = (wr_count != '0);
    assign wr_head = wr_fifo[wr_rptr];

    always_comb begin
        wr_count_nxt = wr_count;
        if (wr_push && !wr_pop) begin
            wr_count_nxt = wr_count + CNT_W'(1);
        end else if (!wr_push && wr_pop) begin
            wr_count_nxt = wr_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_wptr      <= '0;
            wr_rptr      <= '0;
            wr_count     <= '0;
            c1tx_almfull <= 1'b0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + PTR_W'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + PTR_W'(1);
            wr_count     <= wr_count_nxt;
            c1tx_almfull <= (wr_count_nxt >= ALM_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_fifo[wr_wptr] <= '{fence: c1tx_fence, addr: c1tx_addr,
                                  data: c1tx_data, mdata: c1tx_mdata};
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err <= 1'b0;
        end else if ((c0tx_valid && rd_full) || (c1tx_valid && wr_full)) begin
            overflow_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line memory: contents survive reset. A write and a read popped in
    // the same cycle see the old line because both sample on one edge.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (wr_pop && !wr_head.fence) mem[wr_head.addr] <= wr_head.data;
    end

    // Read pipeline: stage 0 is the memory read register.
    logic [RD_LATENCY-1:0]  pipe_v;
    logic [MDATA_WIDTH-1:0] pipe_mdata [RD_LATENCY];
    logic [DATA_WIDTH-1:0]  pipe_data  [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_mdata[i] <= '0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_v[0]     <= rd_pop;
            pipe_mdata[0] <= rd_head.mdata;
            pipe_data[0]  <= mem[rd_head.addr];
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_v[i]     <= pipe_v[i-1];
                pipe_mdata[i] <= pipe_mdata[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign c0rx_rd_valid = pipe_v[RD_LATENCY-1];
    assign c0rx_mdata    = pipe_mdata[RD_LATENCY-1];
    assign c0rx_data     = pipe_data[RD_LATENCY-1];

    // Write/fence acks, one cycle after pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1rx_wr_valid <= 1'b0;
            c1rx_fence    <= 1'b0;
            c1rx_mdata    <= '0;
        end else begin
            c1rx_wr_valid <= wr_pop;
            c1rx_fence    <= wr_pop && wr_head.fence;
            if (wr_pop) c1rx_mdata <= wr_head.mdata;
        end
    end

endmodule
